// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared defaults and FSM state encoding for the program
//               loader (byte-stream boot loader feeding the cpuCore debug
//               write port).
// Contents    : c_xlen_default, c_instr_len_default, c_max_instr_default,
//               state_t and the seven loader state constants.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam int c_xlen_default      = 64;
    localparam int c_instr_len_default = c_xlen_default / 2;
    localparam int c_max_instr_default = 1024;

    // Loader state encoding (3 bits, seven states used).
    typedef logic [2:0] state_t;

    localparam state_t c_st_cnt_lo = 3'd0;  // expecting count low byte
    localparam state_t c_st_cnt_hi = 3'd1;  // expecting count high byte
    localparam state_t c_st_data   = 3'd2;  // collecting instruction bytes
    localparam state_t c_st_write  = 3'd3;  // one-cycle debug-port write
    localparam state_t c_st_check  = 3'd4;  // expecting checksum byte
    localparam state_t c_st_run    = 3'd5;  // image accepted, core running
    localparam state_t c_st_error  = 3'd6;  // image rejected, core held

endpackage : loader_pkg
`default_nettype wire

// File: rtl/instr_assembler.sv
`default_nettype none
// ============================================================================
// Module      : instr_assembler
// Description : Packs little-endian instruction bytes into 32-bit words and
//               keeps the running XOR of every instruction byte seen.
// Ports       : clk, rst (sync, active-low)
//               i_clear     - restart: byte index and XOR back to zero
//               i_byte_en   - accept i_byte as the next instruction byte
//               i_byte      - incoming byte
//               o_word      - assembled word, valid while o_word_done is high
//               o_word_done - the byte being accepted completes a word
//               o_xor       - running XOR of accepted instruction bytes
// Revision    : 1.0 - initial release
// ============================================================================
module instr_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_done,
    output logic [7:0]  o_xor
);

    logic [23:0] r_low_q, w_low_d;
    logic [1:0]  r_idx_q, w_idx_d;
    logic [7:0]  r_xor_q, w_xor_d;

    always_comb begin
        w_low_d = r_low_q;
        w_idx_d = r_idx_q;
        w_xor_d = r_xor_q;
        if (i_clear) begin
            w_low_d = '0;
            w_idx_d = '0;
            w_xor_d = '0;
        end else if (i_byte_en) begin
            case (r_idx_q)
                2'd0:    w_low_d[7:0]   = i_byte;
                2'd1:    w_low_d[15:8]  = i_byte;
                2'd2:    w_low_d[23:16] = i_byte;
                default: w_low_d        = r_low_q;  // 4th byte goes straight out
            endcase
            w_idx_d = r_idx_q + 2'd1;   // wraps to 0 after the 4th byte
            w_xor_d = r_xor_q ^ i_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_low_q <= '0;
            r_idx_q <= '0;
            r_xor_q <= '0;
        end else begin
            r_low_q <= w_low_d;
            r_idx_q <= w_idx_d;
            r_xor_q <= w_xor_d;
        end
    end

    // The top byte is taken live so the word can be captured on the same
    // edge that accepts it.
    assign o_word      = {i_byte, r_low_q};
    assign o_word_done = i_byte_en && (r_idx_q == 2'd3);
    assign o_xor       = r_xor_q;

endmodule : instr_assembler
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Receives a boot image as a byte stream (16-bit count, N
//               little-endian 32-bit instructions, XOR checksum), writes each
//               instruction through the cpuCore debug port and releases the
//               core from reset once the checksum matches.
// Ports       : clk, rst (sync, active-low)
//               byte_valid/byte_data/byte_ready - upstream byte stream
//               reload     - restart loading from RUN or ERROR
//               cpu_rst    - active-high core reset
//               dbg_wr_en/dbg_addr/dbg_instr - debug-port instruction write
//               load_done/load_error - final load status
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import loader_pkg::*;
#(
    parameter int XLEN               = c_xlen_default,
    parameter int INSTRUCTION_LENGTH = XLEN / 2,   // must be >= 32
    parameter int MAX_INSTR          = c_max_instr_default
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          byte_valid,
    input  logic [7:0]                    byte_data,
    output logic                          byte_ready,
    input  logic                          reload,
    output logic                          cpu_rst,
    output logic                          dbg_wr_en,
    output logic [XLEN-1:0]               dbg_addr,
    output logic [INSTRUCTION_LENGTH-1:0] dbg_instr,
    output logic                          load_done,
    output logic                          load_error
);

    state_t                          r_state_q, w_state_d;
    logic [7:0]                      r_cnt_lo_q, w_cnt_lo_d;
    logic [15:0]                     r_count_q, w_count_d;
    logic [15:0]                     r_instr_idx_q, w_instr_idx_d;
    logic                            r_cpu_rst_q, w_cpu_rst_d;
    logic                            r_wr_en_q, w_wr_en_d;
    logic [XLEN-1:0]                 r_addr_q, w_addr_d;
    logic [INSTRUCTION_LENGTH-1:0]   r_instr_q, w_instr_d;
    logic                            r_done_q, w_done_d;
    logic                            r_error_q, w_error_d;

    logic                            w_xfer;
    logic [15:0]                     w_count_rx;
    logic                            w_reload_go;
    logic                            w_asm_byte_en;
    logic [31:0]                     w_word;
    logic                            w_word_done;
    logic [7:0]                      w_xor;
    logic [INSTRUCTION_LENGTH-1:0]   w_word_ext;
    logic [16:0]                     w_next_idx;

    // Ready is decoded straight from state so it drops the moment reset is
    // asserted, before any edge.
    assign byte_ready = rst && ((r_state_q == c_st_cnt_lo) || (r_state_q == c_st_cnt_hi) ||
                                (r_state_q == c_st_data)   || (r_state_q == c_st_check));

    assign w_xfer        = byte_valid && byte_ready;
    assign w_count_rx    = {byte_data, r_cnt_lo_q};
    assign w_reload_go   = reload && ((r_state_q == c_st_run) || (r_state_q == c_st_error));
    assign w_asm_byte_en = w_xfer && (r_state_q == c_st_data);
    assign w_next_idx    = {1'b0, r_instr_idx_q} + 17'd1;

    instr_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_reload_go),
        .i_byte_en   (w_asm_byte_en),
        .i_byte      (byte_data),
        .o_word      (w_word),
        .o_word_done (w_word_done),
        .o_xor       (w_xor)
    );

    always_comb begin
        w_word_ext       = '0;
        w_word_ext[31:0] = w_word;
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_lo_d    = r_cnt_lo_q;
        w_count_d     = r_count_q;
        w_instr_idx_d = r_instr_idx_q;
        w_addr_d      = r_addr_q;
        w_instr_d     = r_instr_q;
        w_wr_en_d     = 1'b0;

        case (r_state_q)
            c_st_cnt_lo: begin
                if (w_xfer) begin
                    w_cnt_lo_d = byte_data;
                    w_state_d  = c_st_cnt_hi;
                end
            end
            c_st_cnt_hi: begin
                if (w_xfer) begin
                    w_count_d = w_count_rx;
                    if (w_count_rx == 16'd0)
                        w_state_d = c_st_check;
                    else if (32'(w_count_rx) > 32'(MAX_INSTR))
                        w_state_d = c_st_error;
                    else
                        w_state_d = c_st_data;
                end
            end
            c_st_data: begin
                // Address and word are captured here and then held until
                // the next write, so the debug port sees stable values.
                if (w_word_done) begin
                    w_state_d = c_st_write;
                    w_wr_en_d = 1'b1;
                    w_addr_d  = XLEN'({r_instr_idx_q, 2'b00});
                    w_instr_d = w_word_ext;
                end
            end
            c_st_write: begin
                w_instr_idx_d = w_next_idx[15:0];
                w_state_d     = (w_next_idx < {1'b0, r_count_q}) ? c_st_data : c_st_check;
            end
            c_st_check: begin
                if (w_xfer)
                    w_state_d = (byte_data == w_xor) ? c_st_run : c_st_error;
            end
            c_st_run, c_st_error: begin
                if (w_reload_go) begin
                    w_state_d     = c_st_cnt_lo;
                    w_cnt_lo_d    = '0;
                    w_count_d     = '0;
                    w_instr_idx_d = '0;
                end
            end
            default: w_state_d = c_st_cnt_lo;
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state register.
        w_cpu_rst_d = (w_state_d != c_st_run);
        w_done_d    = (w_state_d == c_st_run);
        w_error_d   = (w_state_d == c_st_error);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q     <= c_st_cnt_lo;
            r_cnt_lo_q    <= '0;
            r_count_q     <= '0;
            r_instr_idx_q <= '0;
            r_cpu_rst_q   <= 1'b1;
            r_wr_en_q     <= 1'b0;
            r_addr_q      <= '0;
            r_instr_q     <= '0;
            r_done_q      <= 1'b0;
            r_error_q     <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_lo_q    <= w_cnt_lo_d;
            r_count_q     <= w_count_d;
            r_instr_idx_q <= w_instr_idx_d;
            r_cpu_rst_q   <= w_cpu_rst_d;
            r_wr_en_q     <= w_wr_en_d;
            r_addr_q      <= w_addr_d;
            r_instr_q     <= w_instr_d;
            r_done_q      <= w_done_d;
            r_error_q     <= w_error_d;
        end
    end

    assign cpu_rst    = r_cpu_rst_q;
    assign dbg_wr_en  = r_wr_en_q;
    assign dbg_addr   = r_addr_q;
    assign dbg_instr  = r_instr_q;
    assign load_done  = r_done_q;
    assign load_error = r_error_q;

endmodule : program_loader
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Scoreboard bench for program_loader. Images are built from
//               word lists, expected debug writes are queued as each word is
//               sent and popped by an independent monitor on the falling
//               edge. Byte gaps and stray reload pulses are randomized.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int XLEN      = 64;
    localparam int IL        = 32;
    localparam int MAX_INSTR = 1024;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            byte_valid = 1'b0;
    logic [7:0]      byte_data = 8'h00;
    logic            reload = 1'b0;
    logic            byte_ready;
    logic            cpu_rst;
    logic            dbg_wr_en;
    logic [XLEN-1:0] dbg_addr;
    logic [IL-1:0]   dbg_instr;
    logic            load_done;
    logic            load_error;

    always #5 clk = ~clk;

    program_loader #(
        .XLEN               (XLEN),
        .INSTRUCTION_LENGTH (IL),
        .MAX_INSTR          (MAX_INSTR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .reload     (reload),
        .cpu_rst    (cpu_rst),
        .dbg_wr_en  (dbg_wr_en),
        .dbg_addr   (dbg_addr),
        .dbg_instr  (dbg_instr),
        .load_done  (load_done),
        .load_error (load_error)
    );

    typedef struct {
        logic [63:0] addr;
        logic [31:0] instr;
    } wr_t;

    int          vectors     = 0;
    int          miscompares = 0;
    wr_t         exp_q[$];
    logic [31:0] img_q[$];
    int          gap_pct     = 30;
    bit          stray_reload = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every debug write must match the oldest queued expectation.
    always @(negedge clk) begin : mon
        wr_t e;
        if (dbg_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %h instr %h, expected no write",
                         dbg_addr, dbg_instr);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", dbg_addr, e.addr);
                check("wr_instr", {32'd0, dbg_instr}, {32'd0, e.instr});
            end
        end
    end

    // All stimulus tasks start and finish just after a falling edge.
    task automatic send_byte(input logic [7:0] b);
        int waits = 0;
        while ($urandom_range(99) < gap_pct) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            // A reload outside RUN/ERROR must be ignored.
            reload     = stray_reload && ($urandom_range(7) == 0);
            @(negedge clk);
        end
        reload     = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1) begin
            @(negedge clk);
            waits++;
            if (waits > 64) begin
                vectors++;
                miscompares++;
                $display("FAIL byte_ready_timeout: got ready=%b, expected 1", byte_ready);
                byte_valid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    function automatic logic [7:0] ref_checksum(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < n; i++)
            x ^= img_q[i][7:0] ^ img_q[i][15:8] ^ img_q[i][23:16] ^ img_q[i][31:24];
        return x;
    endfunction

    task automatic check_status(input string tag, input bit exp_run, input bit exp_err);
        check({tag, "_load_done"},  {63'd0, load_done},  {63'd0, exp_run});
        check({tag, "_load_error"}, {63'd0, load_error}, {63'd0, exp_err});
        check({tag, "_cpu_rst"},    {63'd0, cpu_rst},    {63'd0, !exp_run});
    endtask

    // Sends count, img_q[0..n-1] and checksum XOR cks_mask, then checks the
    // outcome the stream rules predict.
    task automatic send_image(input string tag, input int n, input logic [7:0] cks_mask);
        logic [15:0] cnt;
        logic [31:0] w;
        bit          exp_run;
        cnt = 16'(n);
        send_byte(cnt[7:0]);
        send_byte(cnt[15:8]);
        if (n > MAX_INSTR) begin
            check_status(tag, 1'b0, 1'b1);
            check({tag, "_ready"}, {63'd0, byte_ready}, 64'd0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            w = img_q[i];
            send_byte(w[7:0]);
            send_byte(w[15:8]);
            send_byte(w[23:16]);
            exp_q.push_back('{addr: 64'(4 * i), instr: w});
            send_byte(w[31:24]);
        end
        send_byte(ref_checksum(n) ^ cks_mask);
        exp_run = (cks_mask == 8'h00);
        check_status(tag, exp_run, !exp_run);
        repeat (2) @(negedge clk);
        check({tag, "_writes_drained"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_ready"}, {63'd0, byte_ready}, 64'd0);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("reload_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        check("reload_done",    {63'd0, load_done}, 64'd0);
        check("reload_ready",   {63'd0, byte_ready}, 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cpu_rst"}, {63'd0, cpu_rst},    64'd1);
        check({tag, "_wr_en"},   {63'd0, dbg_wr_en},  64'd0);
        check({tag, "_addr"},    dbg_addr,            64'd0);
        check({tag, "_instr"},   {32'd0, dbg_instr},  64'd0);
        check({tag, "_done"},    {63'd0, load_done},  64'd0);
        check({tag, "_error"},   {63'd0, load_error}, 64'd0);
        check({tag, "_ready"},   {63'd0, byte_ready}, 64'd0);
    endtask

    task automatic rand_image(input int n);
        img_q.delete();
        for (int i = 0; i < n; i++) img_q.push_back($urandom);
    endtask

    initial begin : stim
        logic [31:0] itype [9];
        itype = '{32'h00100093, 32'h0010A113, 32'h0010B193, 32'h0010C213, 32'h0010E293,
                  32'h0010F313, 32'h00109393, 32'h0010D413, 32'h4010D493};

        // Reset with stray valid bytes.
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Single ADDI, good checksum 0x83.
        img_q = '{32'h00100093};
        check("addi_cks", {56'd0, ref_checksum(1)}, 64'h83);
        send_image("n1", 1, 8'h00);

        // Nine I-type words.
        do_reload();
        img_q.delete();
        foreach (itype[i]) img_q.push_back(itype[i]);
        send_image("n9", 9, 8'h00);

        // Checksum 0x84 instead of 0x83, then recovery.
        do_reload();
        img_q = '{32'h00100093};
        send_image("badcks", 1, 8'h07);
        do_reload();
        rand_image(3);
        send_image("recover", 3, 8'h00);

        // Oversized count.
        do_reload();
        send_image("big", 16'hFFFF, 8'h00);
        // Bytes offered while not ready must change nothing.
        byte_valid = 1'b1;
        repeat (4) @(negedge clk);
        byte_valid = 1'b0;
        check_status("big_hold", 1'b0, 1'b1);

        // Empty image, with different valid patterns.
        gap_pct = 0;
        do_reload();
        img_q.delete();
        send_image("n0_dense", 0, 8'h00);
        gap_pct = 70;
        do_reload();
        send_image("n0_sparse", 0, 8'h00);
        gap_pct = 30;

        // Randomized images, some with corrupted checksums.
        for (int t = 0; t < 8; t++) begin
            do_reload();
            rand_image(1 + $urandom_range(5));
            send_image("rand", img_q.size(),
                       ($urandom_range(2) == 0) ? 8'(1 + $urandom_range(254)) : 8'h00);
        end

        // Reset mid-load after 2 of 4 bytes of the first word.
        do_reload();
        stray_reload = 1'b0;
        rand_image(2);
        send_byte(8'd2);
        send_byte(8'd0);
        send_byte(img_q[0][7:0]);
        send_byte(img_q[0][15:8]);
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_no_write", 64'(exp_q.size()), 64'd0);
        check_status("midrst_idle", 1'b0, 1'b0);
        rand_image(2);
        send_image("fresh", 2, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares",
                 vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_program_loader
`default_nettype wire

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter XLEN, default 64, core data/address width.
REQ-002 Parameter INSTRUCTION_LENGTH, default XLEN/2, instruction width.
REQ-003 Parameter MAX_INSTR, default 1024, largest accepted instruction count.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  one clock; reset is synchronous and active-low.
REQ-006 byte_valid  input  1  upstream byte stream valid.
REQ-007 byte_data  input  8  upstream byte.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready.
REQ-009 reload  input  1  single-cycle request to restart loading.
REQ-010 cpu_rst  output  1  active-high reset driven to cpuCore rst.
REQ-011 dbg_wr_en  output  1  one-cycle write strobe to the cpuCore debug port.
REQ-012 dbg_addr  output  XLEN  byte address of the instruction being written.
REQ-013 dbg_instr  output  INSTRUCTION_LENGTH  instruction being written.
REQ-014 load_done  output  1  image loaded and checksum verified; core running.
REQ-015 load_error  output  1  image rejected; core held in reset.

Function
REQ-016 Stream format SHALL be: count low byte, count high byte (N, 16-bit), N x 4 instruction bytes little-endian, then one checksum byte equal to the XOR of all instruction bytes.
REQ-017 States SHALL be CNT_LO, CNT_HI, DATA, WRITE, CHECK, RUN, ERROR.
REQ-018 byte_ready SHALL be 1 in CNT_LO, CNT_HI, DATA and CHECK, and 0 in WRITE, RUN and ERROR.
REQ-019 CNT_LO -> CNT_HI on a transfer; CNT_HI -> DATA on a transfer if 0 < N <= MAX_INSTR, -> CHECK if N == 0, -> ERROR if N > MAX_INSTR.
REQ-020 In DATA, bytes SHALL fill dbg_instr bits [7:0], [15:8], [23:16], [31:24] in order; accepting the 4th byte in cycle t SHALL enter WRITE at t+1.
REQ-021 In WRITE (exactly 1 cycle), dbg_wr_en SHALL be 1, dbg_addr = 4*k for instruction index k (0-based), and dbg_instr SHALL hold the assembled word.
REQ-022 WRITE SHALL return to DATA if k+1 < N, else go to CHECK.
REQ-023 dbg_addr and dbg_instr SHALL remain stable from WRITE until the next WRITE.
REQ-024 The running XOR SHALL cover instruction bytes only, clear on entering CNT_LO, and be 0 for N == 0.
REQ-025 In CHECK, a matching checksum byte -> RUN, a mismatch -> ERROR, both on the next cycle.
REQ-026 cpu_rst SHALL be 1 in every state except RUN; load_done = 1 only in RUN; load_error = 1 only in ERROR.
REQ-027 reload in RUN or ERROR -> CNT_LO next cycle with cpu_rst = 1; reload in any other state SHALL be ignored.
REQ-028 byte_valid while byte_ready = 0 SHALL be ignored; no byte is consumed.

Reset
REQ-029 rst = 0 at a rising edge -> CNT_LO, cpu_rst = 1, dbg_wr_en = 0, dbg_addr = 0, dbg_instr = 0, load_done = 0, load_error = 0, checksum = 0, counters = 0.
REQ-030 byte_ready SHALL be 0 while rst = 0.
REQ-031 Reset mid-load SHALL abort the load, and no further dbg_wr_en pulse SHALL occur for that image.

Structure
REQ-032 Package loader_pkg SHALL hold the state enum, XLEN/INSTRUCTION_LENGTH defaults and the MAX_INSTR default.
REQ-033 One sub-module, instr_assembler, SHALL do the byte-to-word shifting, the byte index (0-3) and the running XOR.
REQ-034 All outputs SHALL be registered except byte_ready, which decodes from state and rst.

Verification
REQ-035 N = 1, bytes 93 00 10 00, checksum 83 -> one pulse with addr 0, instr 0x00100093, then load_done = 1 and cpu_rst = 0.
REQ-036 N = 9, using the nine I-type words ADDI..SRAI -> pulses at addr 0, 4, ..., 32 with matching words, then RUN.
REQ-037 N = 1 with checksum 84 -> ERROR, load_error = 1, cpu_rst stays 1; reload -> CNT_LO and a reload succeeds.
REQ-038 Count 0xFFFF (greater than MAX_INSTR) -> ERROR right after the count high byte; no dbg_wr_en.
REQ-039 N = 0, checksum 00 -> RUN with no write; byte_valid toggled randomly gives identical results.
REQ-040 rst low after 2 of 4 instruction bytes -> all outputs at reset values; a fresh image loads correctly afterwards.
